// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK state used for trailer verification.
package imem_pkg;

  localparam int DEPTH_DEF = 32;
  localparam int AW_DEF    = 5;

  typedef logic [31:0] word_t;

  localparam word_t HOLD_INSTR = 32'hFFFF_FFFF;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/imem_dpram.sv
// Simple dual-port instruction RAM: one write port and one registered read port.
// A read and a write to the same address in the same cycle return the old contents.
module imem_dpram
  import imem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program image into instruction RAM and holds the core in reset until it is valid.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailer beat compared against a running word sum.
//
// state | meaning
// IDLE  | out of reset, no image, core held
// LOAD  | accepting program words into RAM
// CHECK | waiting for the checksum trailer beat (checksum build only)
// DONE  | image valid, core released
// ERR   | overflow or checksum mismatch, core held
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [31:0]   s_data,
  input  logic          s_last,
  input  logic [AW-1:0] fetch_addr,
  output logic [31:0]   fetch_data,
  output logic          cpu_hold,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   word_count
);

  localparam logic [AW:0] LAST_IDX  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] COUNT_ONE = (AW+1)'(1);

  state_t      state;
  state_t      state_nx;
  logic [AW:0] count_nx;
  logic        wr_en;
  word_t       rd_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  word_t       sum;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      word_count <= '0;
    end else begin
      state      <= state_nx;
      word_count <= count_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    count_nx  = word_count;
    wr_en     = 1'b0;
    s_ready   = 1'b0;
    cpu_hold  = 1'b1;
    load_done = 1'b0;
    load_err  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          count_nx = '0;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        // A restart wins over a beat presented in the same cycle.
        if (start) begin
          count_nx = '0;
        end else if (s_valid) begin
          wr_en    = 1'b1;
          count_nx = word_count + COUNT_ONE;
          if (s_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nx = CHECK;
`else
            state_nx = DONE;
`endif
          end else if (word_count == LAST_IDX) begin
            state_nx = ERR;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        s_ready = 1'b1;
        if (start) begin
          state_nx = LOAD;
          count_nx = '0;
        end else if (s_valid) begin
          state_nx = (s_data == sum) ? DONE : ERR;
        end
      end
`endif
      DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
        if (start) begin
          state_nx = LOAD;
          count_nx = '0;
        end
      end
      ERR: begin
        load_err = 1'b1;
        if (start) begin
          state_nx = LOAD;
          count_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        count_nx = '0;
      end
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum <= '0;
    end else if (start) begin
      sum <= '0;
    end else if (wr_en) begin
      sum <= sum + s_data;
    end
  end
`endif

  // Write address is the word count; ERR is entered before it could wrap.
  imem_dpram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (word_count[AW-1:0]),
    .wdata (s_data),
    .raddr (fetch_addr),
    .rdata (rd_word)
  );

  assign fetch_data = cpu_hold ? HOLD_INSTR : rd_word;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected status/fetch results,
// a negedge monitor pops and compares them when the probe or fetch strobe fires.
module tb_imem_loader;
  import imem_pkg::*;

  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic          s_last = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [31:0]   fetch_data;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .fetch_addr (fetch_addr),
    .fetch_data (fetch_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        done;
    logic        err;
    logic        hold;
    logic        ready;
    logic [AW:0] count;
  } status_t;

  status_t     exp_status_q[$];
  string       status_name_q[$];
  logic [31:0] exp_fetch_q[$];
  string       fetch_name_q[$];

  int          checks = 0;
  int          failures = 0;
  logic        status_req = 1'b0;
  logic        fetch_req = 1'b0;
  logic        fetch_tag = 1'b0;
  logic [31:0] tb_sum = '0;

  status_t     mon_act;
  status_t     mon_exp;
  logic [31:0] mon_fexp;
  string       mon_name;

  always @(posedge clk) fetch_tag <= fetch_req;

  always @(negedge clk) begin
    if (status_req) begin
      mon_act = {load_done, load_err, cpu_hold, s_ready, word_count};
      checks++;
      if (exp_status_q.size() == 0) begin
        failures++;
        $display("FAIL status_underflow: no expected status queued");
      end else begin
        mon_exp  = exp_status_q.pop_front();
        mon_name = status_name_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL %s: got done=%0b err=%0b hold=%0b ready=%0b count=%0d, expected done=%0b err=%0b hold=%0b ready=%0b count=%0d",
                   mon_name, mon_act.done, mon_act.err, mon_act.hold, mon_act.ready, mon_act.count,
                   mon_exp.done, mon_exp.err, mon_exp.hold, mon_exp.ready, mon_exp.count);
        end
      end
    end
    if (fetch_tag) begin
      checks++;
      if (exp_fetch_q.size() == 0) begin
        failures++;
        $display("FAIL fetch_underflow: no expected fetch queued");
      end else begin
        mon_fexp = exp_fetch_q.pop_front();
        mon_name = fetch_name_q.pop_front();
        if (fetch_data !== mon_fexp) begin
          failures++;
          $display("FAIL %s: fetch_data got %h expected %h", mon_name, fetch_data, mon_fexp);
        end
      end
    end
  end

  function automatic status_t mk(input logic d, input logic e, input logic h,
                                 input logic r, input int c);
    return {d, e, h, r, (AW+1)'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input status_t e, input string nm);
    exp_status_q.push_back(e);
    status_name_q.push_back(nm);
    status_req = 1'b1;
    @(negedge clk);
    #1;
    status_req = 1'b0;
  endtask

  task automatic do_fetch(input logic [AW-1:0] a, input logic [31:0] e, input string nm);
    fetch_addr = a;
    exp_fetch_q.push_back(e);
    fetch_name_q.push_back(nm);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    tb_sum = '0;
  endtask

  task automatic send_raw(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 16) begin
      tick();
      n++;
    end
    checks++;
    if (!s_ready) begin
      failures++;
      $display("FAIL beat_timeout: s_ready got 0 expected 1 within 16 cycles");
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    send_raw(d, l);
    tb_sum += d;
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_raw(tb_sum, 1'b0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) tick();
    probe(mk(0, 0, 1, 0, 0), "reset_status");
    do_fetch(5'd0, 32'hFFFF_FFFF, "reset_fetch");
    rst = 1'b1;
    tick();
    probe(mk(0, 0, 1, 0, 0), "idle_status");

    // Basic four-word load
    pulse_start();
    send_beat(32'h11, 1'b0);
    send_beat(32'h22, 1'b0);
    send_beat(32'h33, 1'b0);
    send_beat(32'h44, 1'b1);
    finish_load();
    probe(mk(1, 0, 0, 0, 4), "basic_done");
    do_fetch(5'd2, 32'h33, "basic_fetch2");
    do_fetch(5'd0, 32'h11, "basic_fetch0");
    do_fetch(5'd3, 32'h44, "basic_fetch3");

    // Restart from DONE, reload two words
    pulse_start();
    probe(mk(0, 0, 1, 1, 0), "reload_hold");
    send_beat(32'h55, 1'b0);
    send_beat(32'h66, 1'b1);
    finish_load();
    probe(mk(1, 0, 0, 0, 2), "reload_done");
    do_fetch(5'd0, 32'h55, "reload_fetch0");
    do_fetch(5'd1, 32'h66, "reload_fetch1");
    do_fetch(5'd2, 32'h33, "reload_keeps_old");

    // s_valid toggling every cycle
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send_beat(32'h100 + i, (i == 7));
      if (i < 7) tick();
    end
    finish_load();
    probe(mk(1, 0, 0, 0, 8), "toggle_done");
    for (int i = 0; i < 8; i++) begin
      do_fetch(AW'(i), 32'h100 + i, "toggle_word");
    end

    // Start during LOAD discards the concurrent beat
    pulse_start();
    send_beat(32'hA0, 1'b0);
    start   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'hBAD0_BAD0;
    tick();
    start   = 1'b0;
    s_valid = 1'b0;
    tb_sum  = '0;
    probe(mk(0, 0, 1, 1, 0), "restart_cleared");
    send_beat(32'hC0, 1'b1);
    finish_load();
    probe(mk(1, 0, 0, 0, 1), "restart_done");
    do_fetch(5'd0, 32'hC0, "restart_fetch0");
    do_fetch(5'd1, 32'h101, "restart_discard");

    // Reset in the middle of a load
    pulse_start();
    send_beat(32'hD0, 1'b0);
    send_beat(32'hD1, 1'b0);
    send_beat(32'hD2, 1'b0);
    rst = 1'b0;
    probe(mk(0, 0, 1, 0, 0), "midreset_status");
    do_fetch(5'd1, 32'hFFFF_FFFF, "midreset_fetch");
    rst = 1'b1;
    tick();
    pulse_start();
    send_beat(32'hE0, 1'b0);
    send_beat(32'hE1, 1'b0);
    send_beat(32'hE2, 1'b0);
    send_beat(32'hE3, 1'b1);
    finish_load();
    probe(mk(1, 0, 0, 0, 4), "after_reset_done");
    do_fetch(5'd3, 32'hE3, "after_reset_fetch3");

    // Overflow: DEPTH words without s_last
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      send_beat(32'hF000_0000 + i, 1'b0);
    end
    probe(mk(0, 1, 1, 0, 32), "overflow_err");
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    s_last  = 1'b1;
    repeat (3) tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    probe(mk(0, 1, 1, 0, 32), "overflow_stays_err");
    do_fetch(5'd0, 32'hFFFF_FFFF, "overflow_fetch_hold");
    checks++;
    if (dut.u_ram.mem[0] !== 32'hF000_0000) begin
      failures++;
      $display("FAIL overflow_mem0: got %h expected %h", dut.u_ram.mem[0], 32'hF000_0000);
    end
    pulse_start();
    probe(mk(0, 0, 1, 1, 0), "err_restart");
    send_beat(32'h77, 1'b1);
    finish_load();
    probe(mk(1, 0, 0, 0, 1), "err_reload_done");
    do_fetch(5'd0, 32'h77, "err_reload_fetch0");
    do_fetch(5'd31, 32'hF000_001F, "overflow_last_word");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Trailer matching and mismatching the sum 1+2+3
    pulse_start();
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b1);
    probe(mk(0, 0, 1, 1, 3), "check_waiting");
    send_raw(32'd6, 1'b0);
    probe(mk(1, 0, 0, 0, 3), "checksum_good");
    pulse_start();
    send_beat(32'd1, 1'b0);
    send_beat(32'd2, 1'b0);
    send_beat(32'd3, 1'b1);
    send_raw(32'd7, 1'b0);
    probe(mk(0, 1, 1, 0, 3), "checksum_bad");
`endif

    repeat (2) tick();
    checks++;
    if (exp_status_q.size() != 0 || exp_fetch_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d status and %0d fetch left, expected 0",
               exp_status_q.size(), exp_fetch_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit instruction words held.
REQ-002 SHALL have parameter AW, default 5, address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1 bit, clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit, single-cycle pulse that begins a load.
REQ-006 SHALL have port s_valid, input, 1 bit, upstream word valid.
REQ-007 SHALL have port s_ready, output, 1 bit, loader accepts a word this cycle.
REQ-008 SHALL have port s_data, input, 32 bits, instruction word.
REQ-009 SHALL have port s_last, input, 1 bit, marks the final program word.
REQ-010 SHALL have port fetch_addr, input, AW bits, word address from fetch (byte PC bits [AW+1:2]).
REQ-011 SHALL have port fetch_data, output, 32 bits, registered instruction word.
REQ-012 SHALL have port cpu_hold, output, 1 bit, holds the core in reset while high.
REQ-013 SHALL have port load_done, output, 1 bit, program image valid.
REQ-014 SHALL have port load_err, output, 1 bit, load failed.
REQ-015 SHALL have port word_count, output, AW+1 bits, words written in the current load.

Function
REQ-016 SHALL implement the states IDLE, LOAD, CHECK, DONE and ERR.
REQ-017 IDLE SHALL go to LOAD on start, clearing the write address and word_count to 0.
REQ-018 In LOAD, s_ready SHALL be 1; a beat is accepted only when s_valid and s_ready are both 1.
REQ-019 An accepted beat in LOAD SHALL write mem[addr], increment addr, and increment word_count.
REQ-020 An accepted beat with s_last=1 SHALL go to DONE when checksum is compiled out, and to CHECK when it is compiled in.
REQ-021 If the DEPTH-th word is accepted with s_last=0, the block SHALL go to ERR (overflow), and no memory write SHALL wrap to address 0.
REQ-022 DONE SHALL drive cpu_hold=0, load_done=1 and s_ready=0.
REQ-023 ERR SHALL drive cpu_hold=1, load_err=1 and s_ready=0.
REQ-024 start in DONE or ERR SHALL re-enter LOAD, clear load_done, load_err, addr and word_count, and raise cpu_hold in the next cycle.
REQ-025 start while in LOAD or CHECK SHALL restart the load from address 0; any beat accepted in that same cycle is discarded.
REQ-026 cpu_hold SHALL be 1 in IDLE, LOAD and CHECK.
REQ-027 fetch_data SHALL equal mem[fetch_addr] one cycle after fetch_addr is presented.
REQ-028 On a read and write to the same address in the same cycle, fetch_data SHALL return the old contents.
REQ-029 While cpu_hold=1, fetch_data SHALL read 32'hFFFFFFFF.

Reset
REQ-030 When rst=0, the block SHALL go to IDLE with cpu_hold=1, load_done=0, load_err=0, s_ready=0, word_count=0 and fetch_data=32'hFFFFFFFF.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 A reset in the middle of a load SHALL abandon the load, and the partial image SHALL be treated as invalid.

Configuration
REQ-033 Macro IMEM_LOADER_CHECKSUM_EN SHALL select the checksum feature.
REQ-034 With IMEM_LOADER_CHECKSUM_EN defined, the block SHALL keep a running 32-bit sum modulo 2^32 of the words written.
REQ-035 With IMEM_LOADER_CHECKSUM_EN defined, CHECK SHALL accept exactly one trailer beat, which is not written to memory.
REQ-036 With IMEM_LOADER_CHECKSUM_EN defined, a trailer equal to the sum SHALL go to DONE, and any other value SHALL go to ERR.
REQ-037 Without IMEM_LOADER_CHECKSUM_EN, the CHECK state and the sum logic SHALL be absent.

Structure
REQ-038 Package imem_pkg SHALL hold the state enum, DEPTH/AW defaults, the HOLD_INSTR=32'hFFFFFFFF constant and the word type.
REQ-039 Sub-module imem_dpram SHALL hold the simple dual-port RAM (one write port, one registered read port).
REQ-040 The FSM, counters and checksum SHALL reside in imem_loader.

Verification
REQ-041 Reset, start, then 4 beats 0x11,0x22,0x33,0x44 with s_last on the 4th SHALL give load_done=1, cpu_hold=0 and word_count=4; fetch_addr=2 SHALL give fetch_data=0x33 one cycle later.
REQ-042 32 beats without s_last SHALL give load_err=1, cpu_hold=1, word_count=32, and mem[0] unchanged.
REQ-043 Toggling s_valid on and off every cycle over 8 words SHALL give word_count=8 and all words stored in order.
REQ-044 With the checksum compiled in, words 1,2,3 with trailer 6 SHALL give load_done=1, and the same words with trailer 7 SHALL give load_err=1.
REQ-045 Driving rst low after 3 beats SHALL give cpu_hold=1, word_count=0 and fetch_data=0xFFFFFFFF; a new start and full load SHALL then give load_done=1.
REQ-046 A start pulse in DONE SHALL raise cpu_hold in the next cycle, and reloading 2 words SHALL give load_done=1 with word_count=2.
